radix4_ntt_ctrl: RTL and testbench
==================================

Name: radix4_ntt_ctrl

Overview:
Sequencer for the combinational radix-4 NTT/INTT butterfly datapath. On a start pulse it walks all log4(N) stages in place. For each butterfly it issues the four coefficient read addresses, the three twiddle exponents and the mode select. After a fixed datapath latency it issues the matching write-back addresses, and it drains the pipeline between stages to avoid read-after-write hazards. It sits between the top-level NTT FSM / host and the coefficient RAM banks, twiddle ROM and butterfly.

Parameters:
STAGES, 2, number of radix-4 stages; N = 4^STAGES coefficients (min 1, max 8)
LATENCY, 3, cycles from read issue to butterfly result valid at the write port (min 1, max 15)
ADDR_W, 2*STAGES, coefficient address / twiddle exponent width (derived, do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a transform; sampled only in IDLE
mode  input  1  0 = NTT, 1 = INTT; latched when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final write-back
sel  output  1  latched mode, driven to the butterfly select input
stage_idx  output  3  current stage s
rd_valid  output  1  read addresses/twiddles valid this cycle
rd_addr_1..rd_addr_4  output  ADDR_W each  butterfly input addresses
tw_idx_2..tw_idx_4  output  ADDR_W each  twiddle exponents, mod N
wr_valid  output  1  write-back enable
wr_addr_1..wr_addr_4  output  ADDR_W each  write-back addresses

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all outputs 0; FSM in IDLE; counters and delay line cleared.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: start=1 latches mode into sel, sets s=0, b=0 and moves to ISSUE. start=0 stays.
  - ISSUE: rd_valid=1 every cycle, one butterfly per cycle, b increments. At b=N/4-1, clear b, preload the drain counter to LATENCY and go to DRAIN.
  - DRAIN: rd_valid=0; count down LATENCY cycles. At 0: if s=STAGES-1 go to FINISH; else increment s and go to ISSUE.
  - FINISH: done=1 for one cycle, busy drops in the same cycle, then go to IDLE.
- Addressing (decimation-in-frequency, in place):
  - span = 4^(STAGES-1-s); g = b / span; j = b mod span.
  - base = g*4*span + j; rd_addr_k = base + (k-1)*span.
  - e = j*4^s; tw_idx_2 = e, tw_idx_3 = 2e mod N, tw_idx_4 = 3e mod N, all truncated to ADDR_W.
  - Shifts only; no multipliers or dividers.
- Write-back: a LATENCY-deep shift register carries rd_valid and rd_addr_1..4. wr_valid and wr_addr_k equal their read values from exactly LATENCY cycles earlier.
- Stage ordering: the first read of stage s+1 occurs the cycle after the last write of stage s.
- Total transform time: start accepted at cycle 0 → done at cycle STAGES*(N/4 + LATENCY) + 1.
- start while busy: ignored, and mode is not relatched.
- rst_n low mid-transform: immediate return to IDLE. The delay line is flushed, so no spurious wr_valid is produced after release.
- sel is held constant for the whole transform.

Optional Feature:
Macro RADIX4_NTT_CTRL_STALL_EN.
- Defined: adds input port stall (1 bit).
  - In ISSUE, stall=1 holds b and forces rd_valid=0; the inserted bubble travels down the delay line.
  - In DRAIN, stall freezes the drain counter.
  - Write-back ordering and addresses are unchanged; only timing shifts.
- Undefined: no stall port; issue is unconditional, one butterfly per cycle.

Test Plan:
1. STAGES=2, LATENCY=3, start with mode=0 at cycle 0:
   - stage 0, b=0 → rd 0,4,8,12, tw 0,0,0;
   - b=1 → rd 1,5,9,13, tw 1,2,3;
   - b=3 → rd 3,7,11,15, tw 3,6,9;
   - done pulse at cycle 15.
2. Same run, stage 1 (span=1): b=0 → rd 0,1,2,3; b=2 → rd 8,9,10,11; all tw 0. First stage-1 rd_valid at cycle 8, last stage-0 wr_valid at cycle 7.
3. Delay check: every wr_addr_k equals the rd_addr_k from 3 cycles earlier; wr_valid is high for exactly 8 cycles total.
4. start=1 with mode=1, then start=1 with mode=0 at cycle 5 → second start ignored; sel stays 1 until done; exactly one done pulse.
5. rst_n asserted at cycle 6 → all outputs 0 immediately; no wr_valid after release; a new start runs the full sequence normally.
6. With RADIX4_NTT_CTRL_STALL_EN: stall high for 2 cycles during stage-0 b=2 → rd sequence unchanged apart from a 2-cycle gap; done at cycle 17.

Source files
------------

// File: rtl/radix4_ntt_ctrl.sv
// radix4_ntt_ctrl: sequencer for a combinational radix-4 NTT/INTT butterfly.
// On an accepted start it walks all STAGES stages in place, one butterfly per
// cycle. For each butterfly it issues four coefficient read addresses, three
// twiddle exponents and the mode select. The read side is replayed through a
// LATENCY-deep delay line as the write-back, and the pipeline is drained
// between stages so a stage never reads data that is still in flight.
//
// Optional feature: define RADIX4_NTT_CTRL_STALL_EN to add the 'stall' input.
// A stall holds the butterfly counter (or the drain counter) for one cycle and
// injects a bubble (rd_valid=0) that travels down the delay line.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, mode        begin request (sampled in IDLE), 0=NTT / 1=INTT
//   stall              (optional) hold issue/drain for this cycle
//   busy, done         transform in progress / one-cycle completion pulse
//   sel                mode latched at start, held for the whole transform
//   stage_idx          current stage
//   rd_valid, rd_addr_1..4, tw_idx_2..4   read-side butterfly request
//   wr_valid, wr_addr_1..4                write-back, LATENCY cycles later
module radix4_ntt_ctrl #(
  parameter int unsigned  STAGES  = 2,
  parameter int unsigned  LATENCY = 3,
  localparam int unsigned ADDR_W  = 2 * STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
`ifdef RADIX4_NTT_CTRL_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic              sel,
  output logic [2:0]        stage_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic [ADDR_W-1:0] rd_addr_2,
  output logic [ADDR_W-1:0] rd_addr_3,
  output logic [ADDR_W-1:0] rd_addr_4,
  output logic [ADDR_W-1:0] tw_idx_2,
  output logic [ADDR_W-1:0] tw_idx_3,
  output logic [ADDR_W-1:0] tw_idx_4,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr_1,
  output logic [ADDR_W-1:0] wr_addr_2,
  output logic [ADDR_W-1:0] wr_addr_3,
  output logic [ADDR_W-1:0] wr_addr_4
);

  localparam int unsigned       CW     = 4;
  localparam int unsigned       SW     = 3;
  localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'((1 << (ADDR_W - 2)) - 1);
  localparam logic [SW-1:0]     S_LAST = SW'(STAGES - 1);
  localparam logic [CW-1:0]     LAT    = CW'(LATENCY);
  localparam logic [3:0]        SH_MAX = 4'(2 * (STAGES - 1));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdv_q, rdv_d;
  logic [ADDR_W-1:0] rda_q [4];
  logic [ADDR_W-1:0] rda_d [4];
  logic [ADDR_W-1:0] tw_q  [3];
  logic [ADDR_W-1:0] tw_d  [3];
  logic              dv_q  [LATENCY];
  logic [ADDR_W-1:0] da_q  [LATENCY][4];

  logic              stall_w;
  logic              emit;
  logic [SW-1:0]     emit_s;
  logic [ADDR_W-1:0] emit_b;
  logic [3:0]        sh;
  logic [ADDR_W-1:0] span, mask, base, e;

`ifdef RADIX4_NTT_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Next-state logic. b_q is the next butterfly to issue; 'emit' registers a
  // read request so that the outputs line up with the cycle after the decision.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    emit    = 1'b0;
    emit_s  = s_q;
    emit_b  = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = mode;
          s_d    = '0;
          emit   = 1'b1;
          emit_s = '0;
          emit_b = '0;
        end
      end
      ISSUE: begin
        if (!stall_w) emit = 1'b1;
      end
      DRAIN: begin
        if (!stall_w) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (s_q == S_LAST) begin
            state_d = FINISH;
          end else begin
            s_d    = s_q + SW'(1);
            emit   = 1'b1;
            emit_s = s_q + SW'(1);
            emit_b = '0;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Advance the butterfly pointer; the last butterfly of a stage starts the drain.
    if (emit) begin
      if (emit_b == B_LAST) begin
        state_d = DRAIN;
        b_d     = '0;
        cnt_d   = LAT;
      end else begin
        state_d = ISSUE;
        b_d     = emit_b + ADDR_W'(1);
      end
    end
  end

  // DIF addressing with shifts: span = 4^(STAGES-1-s), group bits sit above
  // the two butterfly-leg bits, so leg k is just OR-ed in at position sh.
  always_comb begin
    sh   = SH_MAX - {emit_s, 1'b0};
    span = ADDR_W'(1) << sh;
    mask = span - ADDR_W'(1);
    base = ((emit_b >> sh) << ({1'b0, sh} + 5'd2)) | (emit_b & mask);
    e    = (emit_b & mask) << {emit_s, 1'b0};
    for (int k = 0; k < 4; k++) begin
      rda_d[k] = emit ? (base | (ADDR_W'(k) << sh)) : '0;
    end
    tw_d[0] = emit ? e : '0;
    tw_d[1] = emit ? (e << 1) : '0;
    tw_d[2] = emit ? (e + (e << 1)) : '0;
    rdv_d   = emit;
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == FINISH);
  end

  // State, output registers and the write-back delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      for (int k = 0; k < 4; k++) rda_q[k] <= '0;
      for (int k = 0; k < 3; k++) tw_q[k] <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dv_q[i] <= 1'b0;
        for (int k = 0; k < 4; k++) da_q[i][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      rda_q   <= rda_d;
      tw_q    <= tw_d;
      dv_q[0] <= rdv_q;
      da_q[0] <= rda_q;
      for (int i = 1; i < LATENCY; i++) begin
        dv_q[i] <= dv_q[i-1];
        da_q[i] <= da_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sel       = sel_q;
  assign stage_idx = s_q;
  assign rd_valid  = rdv_q;
  assign rd_addr_1 = rda_q[0];
  assign rd_addr_2 = rda_q[1];
  assign rd_addr_3 = rda_q[2];
  assign rd_addr_4 = rda_q[3];
  assign tw_idx_2  = tw_q[0];
  assign tw_idx_3  = tw_q[1];
  assign tw_idx_4  = tw_q[2];
  assign wr_valid  = dv_q[LATENCY-1];
  assign wr_addr_1 = da_q[LATENCY-1][0];
  assign wr_addr_2 = da_q[LATENCY-1][1];
  assign wr_addr_3 = da_q[LATENCY-1][2];
  assign wr_addr_4 = da_q[LATENCY-1][3];

endmodule

// File: tb/tb_radix4_ntt_ctrl.sv
`timescale 1ns/1ps
module tb_radix4_ntt_ctrl;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned AW      = 2 * STAGES;
  localparam int N      = 1 << (2 * STAGES);
  localparam int Q      = N / 4;
  localparam int PER    = Q + LATENCY;
  localparam int DONE_R = STAGES * PER + 1;

  logic          clk, rst_n, start, mode, stall_drv;
  logic          busy, done, sel, rd_valid, wr_valid;
  logic [2:0]    stage_idx;
  logic [AW-1:0] rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4;
  logic [AW-1:0] tw_idx_2, tw_idx_3, tw_idx_4;
  logic [AW-1:0] wr_addr_1, wr_addr_2, wr_addr_3, wr_addr_4;

  radix4_ntt_ctrl #(.STAGES(STAGES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
`ifdef RADIX4_NTT_CTRL_STALL_EN
    .stall(stall_drv),
`endif
    .busy(busy), .done(done), .sel(sel), .stage_idx(stage_idx),
    .rd_valid(rd_valid), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_addr_3(rd_addr_3), .rd_addr_4(rd_addr_4),
    .tw_idx_2(tw_idx_2), .tw_idx_3(tw_idx_3), .tw_idx_4(tw_idx_4),
    .wr_valid(wr_valid), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2),
    .wr_addr_3(wr_addr_3), .wr_addr_4(wr_addr_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pow4(input int x);
    int r = 1;
    for (int i = 0; i < x; i++) r = r * 4;
    return r;
  endfunction

  // Reference model: transform seen as a timeline of virtual cycles m = 1..DONE_R.
  // Stage s occupies PER cycles: Q reads then LATENCY drain cycles.
  bit running = 0;
  int m       = 0;
  bit bubble  = 0;
  bit sel_e   = 0;
  bit e_busy = 0, e_done = 0, e_rdv = 0, e_wv = 0;
  int e_s = 0;
  int e_a [4];
  int e_tw[3];
  int e_wa[4];
  bit h_v [LATENCY];
  int h_a [LATENCY][4];

  function automatic bit f_busy(input int mm);
    return (mm >= 1) && (mm <= STAGES * PER);
  endfunction

  task automatic model_outputs();
    int s, b, span, g, j, base, ee;
    e_busy = 0; e_done = 0; e_rdv = 0; e_s = 0;
    for (int k = 0; k < 4; k++) e_a[k] = 0;
    for (int k = 0; k < 3; k++) e_tw[k] = 0;
    if (running) begin
      if (bubble) begin
        e_busy = 1;
      end else begin
        e_busy = f_busy(m);
        e_done = (m == DONE_R);
        if (e_busy && ((m - 1) % PER) < Q) begin
          s    = (m - 1) / PER;
          b    = (m - 1) % PER;
          span = pow4(STAGES - 1 - s);
          g    = b / span;
          j    = b % span;
          base = g * 4 * span + j;
          ee   = j * pow4(s);
          e_rdv = 1;
          e_s   = s;
          for (int k = 0; k < 4; k++) e_a[k] = base + k * span;
          e_tw[0] = ee % N;
          e_tw[1] = (2 * ee) % N;
          e_tw[2] = (3 * ee) % N;
        end
      end
    end
    e_wv = h_v[LATENCY-1];
    for (int k = 0; k < 4; k++) e_wa[k] = h_a[LATENCY-1][k];
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin e_a[k] = 0; e_wa[k] = 0; end
    for (int k = 0; k < 3; k++) e_tw[k] = 0;
    for (int i = 0; i < LATENCY; i++) begin
      h_v[i] = 0;
      for (int k = 0; k < 4; k++) h_a[i][k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        running = 0; m = 0; bubble = 0; sel_e = 0;
        for (int i = 0; i < LATENCY; i++) begin
          h_v[i] = 0;
          for (int k = 0; k < 4; k++) h_a[i][k] = 0;
        end
      end else begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          h_v[i] = h_v[i-1];
          for (int k = 0; k < 4; k++) h_a[i][k] = h_a[i-1][k];
        end
        h_v[0] = e_rdv;
        for (int k = 0; k < 4; k++) h_a[0][k] = e_a[k];
        if (!running) begin
          if (start) begin
            running = 1; m = 1; bubble = 0; sel_e = mode;
          end
        end else if (stall_drv && f_busy(m)) begin
          bubble = 1;
        end else begin
          bubble = 0;
          m++;
          if (m > DONE_R) running = 0;
        end
      end
      model_outputs();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_sel", 32'(sel), 0);
      end else begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
        chk("wr_valid", 32'(wr_valid), 32'(e_wv));
        chk("sel", 32'(sel), 32'(sel_e));
        if (e_rdv) begin
          chk("stage_idx", 32'(stage_idx), e_s);
          chk("rd_addr_1", 32'(rd_addr_1), e_a[0]);
          chk("rd_addr_2", 32'(rd_addr_2), e_a[1]);
          chk("rd_addr_3", 32'(rd_addr_3), e_a[2]);
          chk("rd_addr_4", 32'(rd_addr_4), e_a[3]);
          chk("tw_idx_2", 32'(tw_idx_2), e_tw[0]);
          chk("tw_idx_3", 32'(tw_idx_3), e_tw[1]);
          chk("tw_idx_4", 32'(tw_idx_4), e_tw[2]);
        end
        if (e_wv) begin
          chk("wr_addr_1", 32'(wr_addr_1), e_wa[0]);
          chk("wr_addr_2", 32'(wr_addr_2), e_wa[1]);
          chk("wr_addr_3", 32'(wr_addr_3), e_wa[2]);
          chk("wr_addr_4", 32'(wr_addr_4), e_wa[3]);
        end
      end
    end
  end

  task automatic lit_rd(input string tag, input int s, input int a1, input int a2,
                        input int a3, input int a4, input int t2, input int t3, input int t4);
    chk({tag, "_rv"}, 32'(rd_valid), 1);
    chk({tag, "_stage"}, 32'(stage_idx), s);
    chk({tag, "_a1"}, 32'(rd_addr_1), a1);
    chk({tag, "_a2"}, 32'(rd_addr_2), a2);
    chk({tag, "_a3"}, 32'(rd_addr_3), a3);
    chk({tag, "_a4"}, 32'(rd_addr_4), a4);
    chk({tag, "_t2"}, 32'(tw_idx_2), t2);
    chk({tag, "_t3"}, 32'(tw_idx_3), t3);
    chk({tag, "_t4"}, 32'(tw_idx_4), t4);
  endtask

  initial begin
    int wcnt, dcnt;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; stall_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_stage", 32'(stage_idx), 0);
    chk("reset_rd_addr_1", 32'(rd_addr_1), 0);
    chk("reset_tw_idx_3", 32'(tw_idx_3), 0);
    chk("reset_wr_addr_4", 32'(wr_addr_4), 0);
    rst_n = 1'b1;
    step();

    // Directed NTT run with hand-computed expectations.
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    wcnt = 0; dcnt = 0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      case (r)
        1:  lit_rd("s0b0", 0, 0, 4, 8, 12, 0, 0, 0);
        2:  lit_rd("s0b1", 0, 1, 5, 9, 13, 1, 2, 3);
        4:  lit_rd("s0b3", 0, 3, 7, 11, 15, 3, 6, 9);
        7: begin
          chk("last_s0_wr_valid", 32'(wr_valid), 1);
          chk("last_s0_wr_addr_1", 32'(wr_addr_1), 3);
          chk("last_s0_wr_addr_4", 32'(wr_addr_4), 15);
          chk("drain_rd_valid", 32'(rd_valid), 0);
        end
        8:  lit_rd("s1b0", 1, 0, 1, 2, 3, 0, 0, 0);
        10: lit_rd("s1b2", 1, 8, 9, 10, 11, 0, 0, 0);
        15: begin
          chk("done_at_15", 32'(done), 1);
          chk("busy_low_at_15", 32'(busy), 0);
        end
        default: ;
      endcase
      if (wr_valid) wcnt++;
      if (done) dcnt++;
      step();
    end
    chk("wr_valid_cycles", wcnt, 8);
    chk("done_pulses", dcnt, 1);

    // INTT run with an ignored second start carrying mode=0.
    start = 1'b1; mode = 1'b1;
    step();
    dcnt = 0;
    for (int r = 1; r <= 18; r++) begin
      if (r == 5) begin start = 1'b1; mode = 1'b0; end
      else start = 1'b0;
      @(negedge clk);
      if (r == 10 || r == 15 || r == 17) chk("sel_held", 32'(sel), 1);
      if (done) dcnt++;
      step();
    end
    start = 1'b0;
    chk("done_pulses_restart", dcnt, 1);

    // Reset in the middle of a transform.
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wr_valid", 32'(wr_valid), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_wr_addr_1", 32'(wr_addr_1), 0);
    chk("midrst_stage", 32'(stage_idx), 0);
    step();
    step();
    rst_n = 1'b1;
    wcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_valid) wcnt++;
      step();
    end
    chk("wr_after_reset", wcnt, 0);
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    wcnt = 0; dcnt = 0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      if (r == 15) chk("post_rst_done_at_15", 32'(done), 1);
      if (wr_valid) wcnt++;
      if (done) dcnt++;
      step();
    end
    chk("post_rst_wr_cycles", wcnt, 8);
    chk("post_rst_done_pulses", dcnt, 1);

`ifdef RADIX4_NTT_CTRL_STALL_EN
    // Two stall cycles while stage-0 butterfly 2 is on the read port.
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    for (int r = 1; r <= 18; r++) begin
      stall_drv = (r == 3 || r == 4);
      @(negedge clk);
      if (r == 4 || r == 5) chk("stall_gap", 32'(rd_valid), 0);
      if (r == 6) lit_rd("stall_s0b3", 0, 3, 7, 11, 15, 3, 6, 9);
      if (r == 17) chk("stall_done_at_17", 32'(done), 1);
      step();
    end
    stall_drv = 1'b0;
`endif

    // Randomized traffic: starts (also while busy), modes, rare resets.
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom_range(0, 1));
`ifdef RADIX4_NTT_CTRL_STALL_EN
      stall_drv = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    start = 1'b0;
    stall_drv = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
